id_ex_operand_stage: RTL and testbench

- Decode/operand stage sitting directly downstream of the 32x32 register file.
- Takes the file's combinational read data (ReadData1/ReadData2) plus the decoded instruction fields and resolves RAW hazards by forwarding from MEM and WB. It stalls when forwarding cannot resolve the hazard.
- Registers the resolved operands into the ID/EX pipeline register that feeds the ALU.
- Holds a saturating stall-cycle counter for performance debug.

---
 rtl/id_ex_operand_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: per-source MEM/WB forwarding, load-use and EX-producer
// hazard detection, the ID/EX pipeline register and a saturating stall counter.

module operand_resolve #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              idValid,
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  input  logic [DATA_W-1:0] rfData,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic              memMemRead,
  input  logic [REG_AW-1:0] memWaddr,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbRegWrite,
  input  logic [REG_AW-1:0] wbWaddr,
  input  logic [DATA_W-1:0] wbWdata,
  input  logic              exValid,
  input  logic              exRegWrite,
  input  logic [REG_AW-1:0] exDst,
  output logic [DATA_W-1:0] operand,
  output logic              hazard
);
  logic srcZero, memFwd, wbFwd, exHit, loadHit;

  assign srcZero = (src == '0);
  assign memFwd  = memValid && memRegWrite && !memMemRead && (memWaddr == src);
  assign wbFwd   = wbRegWrite && (wbWaddr == src);
  // A load in MEM has no data yet, and an EX producer has nothing to forward.
  assign exHit   = exValid && exRegWrite && (exDst == src);
  assign loadHit = memValid && memRegWrite && memMemRead && (memWaddr == src);

  always_comb begin
    operand = rfData;
    if (srcZero)     operand = '0;
    else if (memFwd) operand = memResult;
    else if (wbFwd)  operand = wbWdata;
  end

  assign hazard = idValid && uses && !srcZero && (exHit || loadHit);
endmodule

module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][REG_AW-1:0] srcAddr;
  logic [NUM_SRC-1:0][DATA_W-1:0] rfData;
  logic [NUM_SRC-1:0][DATA_W-1:0] operand;
  logic [NUM_SRC-1:0]             srcUse;
  logic [NUM_SRC-1:0]             srcHaz;
  logic                           hazard;

  assign srcAddr = {id_rt, id_rs};
  assign rfData  = {rf_rdata2, rf_rdata1};
  assign srcUse  = {id_uses_rt, id_uses_rs};

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
    operand_resolve #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uRes (
      .idValid    (id_valid),
      .src        (srcAddr[g]),
      .uses       (srcUse[g]),
      .rfData     (rfData[g]),
      .memValid   (mem_valid),
      .memRegWrite(mem_reg_write),
      .memMemRead (mem_mem_read),
      .memWaddr   (mem_waddr),
      .memResult  (mem_result),
      .wbRegWrite (wb_reg_write),
      .wbWaddr    (wb_waddr),
      .wbWdata    (wb_wdata),
      .exValid    (ex_valid),
      .exRegWrite (ex_reg_write),
      .exDst      (ex_dst),
      .operand    (operand[g]),
      .hazard     (srcHaz[g])
    );
  end

  assign hazard = |srcHaz;
  // MEM-stage load inputs can still match during reset, so gate explicitly.
  assign stall_out = reset_n && hazard && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall_out && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_ctrl      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (flush || hazard) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_op_a      <= operand[0];
      ex_op_b      <= operand[1];
      ex_imm       <= id_imm;
      ex_rt        <= id_rt;
      ex_dst       <= id_dst;
      ex_ctrl      <= id_ctrl;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
    end
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: reference model of the forwarding/stall rules,
// a priority vector table, hand sequences for multi-cycle cases, random traffic.

module tb_id_ex_operand_stage;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_imm, rf_rdata1, rf_rdata2;
  logic [7:0]  id_ctrl;
  logic        mem_valid, mem_reg_write, mem_mem_read;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        stall_out, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_rt, ex_dst;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_count;

  id_ex_operand_stage dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_waddr(mem_waddr), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model of what EX should hold.
  bit          mValid, mRegWrite, mMemRead, mMemKnown;
  logic [31:0] mOpA, mOpB, mImm;
  logic [4:0]  mRt, mDst;
  logic [7:0]  mCtrl;
  int          mCnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] src, input logic [31:0] rf);
    if (src == 0) return 32'd0;
    if (mem_valid && mem_reg_write && !mem_mem_read && mem_waddr == src) return mem_result;
    if (wb_reg_write && wb_waddr == src) return wb_wdata;
    return rf;
  endfunction

  function automatic bit needs(input logic [4:0] src, input logic uses);
    bit exProd, memLoad;
    exProd  = mValid && mRegWrite && mDst == src;
    memLoad = mem_valid && mem_reg_write && mem_mem_read && mem_waddr == src;
    return id_valid && uses && src != 0 && (exProd || memLoad);
  endfunction

  task automatic modelReset();
    mValid = 0; mRegWrite = 0; mMemRead = 0; mMemKnown = 1;
    mOpA = 0; mOpB = 0; mImm = 0; mRt = 0; mDst = 0; mCtrl = 0; mCnt = 0;
  endtask

  task automatic clearIn();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_dst = 0;
    id_reg_write = 0; id_mem_read = 0; id_imm = 0; id_ctrl = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; mem_valid = 0; mem_reg_write = 0; mem_mem_read = 0;
    mem_waddr = 0; mem_result = 0; wb_reg_write = 0; wb_waddr = 0; wb_wdata = 0; flush = 0;
  endtask

  // One clock: check stall_out on settled inputs, advance the model, check EX.
  task automatic step();
    bit haz, expStall;
    logic [31:0] a, b;
    #1;
    haz = needs(id_rs, id_uses_rs) || needs(id_rt, id_uses_rt);
    expStall = haz && !flush;
    check("stall_out", stall_out, expStall);
    a = resolve(id_rs, rf_rdata1);
    b = resolve(id_rt, rf_rdata2);
    @(posedge clock);
    #1;
    if (expStall && mCnt < 65535) mCnt++;
    if (flush) begin
      mValid = 0; mRegWrite = 0; mMemKnown = 0;
    end else if (haz) begin
      mValid = 0; mRegWrite = 0; mMemRead = 0; mMemKnown = 1;
    end else begin
      mValid = id_valid; mRegWrite = id_valid && id_reg_write;
      mMemRead = id_valid && id_mem_read; mMemKnown = 1;
      mOpA = a; mOpB = b; mImm = id_imm; mRt = id_rt; mDst = id_dst; mCtrl = id_ctrl;
    end
    check("ex_valid", ex_valid, mValid);
    check("ex_reg_write", ex_reg_write, mRegWrite);
    check("stall_count", stall_count, mCnt);
    if (mMemKnown) check("ex_mem_read", ex_mem_read, mMemRead);
    if (mValid) begin
      check("ex_op_a", ex_op_a, mOpA);
      check("ex_op_b", ex_op_b, mOpB);
      check("ex_imm", ex_imm, mImm);
      check("ex_rt", ex_rt, mRt);
      check("ex_dst", ex_dst, mDst);
      check("ex_ctrl", ex_ctrl, mCtrl);
    end
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic        memV, memW, memLoad;
    logic [4:0]  memA;
    logic [31:0] memR;
    logic        wbW;
    logic [4:0]  wbA;
    logic [31:0] wbD, rf1, rf2, expA, expB;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int savedCnt;
    vecs[0] = '{5'd11, 5'd12, 1, 1, 0, 5'd11, 32'd1, 1, 5'd11, 32'd2, 32'd3, 32'd4, 32'd1, 32'd4};
    vecs[1] = '{5'd0,  5'd11, 1, 1, 0, 5'd0,  32'd7, 1, 5'd11, 32'd2, 32'd3, 32'd4, 32'd0, 32'd2};
    vecs[2] = '{5'd5,  5'd5,  0, 1, 0, 5'd5,  32'd9, 0, 5'd5,  32'd8, 32'h55, 32'h66, 32'h55, 32'h66};
    vecs[3] = '{5'd6,  5'd7,  1, 0, 0, 5'd6,  32'd9, 1, 5'd7,  32'hAA, 32'd1, 32'd2, 32'd1, 32'hAA};
    vecs[4] = '{5'd3,  5'd3,  1, 1, 1, 5'd3,  32'd9, 1, 5'd3,  32'h33, 32'd1, 32'd2, 32'h33, 32'h33};
    vecs[5] = '{5'd0,  5'd0,  1, 1, 0, 5'd0,  32'd9, 1, 5'd0,  32'h44, 32'd1, 32'd2, 32'd0, 32'd0};

    // Reset with a live load-use pattern on the inputs.
    clearIn();
    modelReset();
    reset_n = 0;
    id_valid = 1; id_rs = 4; id_uses_rs = 1; id_reg_write = 1; id_dst = 7;
    id_imm = $urandom; rf_rdata1 = $urandom; id_ctrl = 8'h5A;
    mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_waddr = 4;
    repeat (2) @(posedge clock);
    #2;
    check("rst_stall_out", stall_out, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_op_a", ex_op_a, 0);
    check("rst_ex_dst", ex_dst, 0);
    check("rst_ex_reg_write", ex_reg_write, 0);
    check("rst_stall_count", stall_count, 0);
    reset_n = 1;
    clearIn();
    id_valid = 1; id_rs = 8; id_uses_rs = 1; rf_rdata1 = 5;
    step();
    check("post_rst_op_a", ex_op_a, 5);

    // ALU producer directly ahead: one stall, then forward from MEM.
    clearIn();
    id_valid = 1; id_dst = 9; id_reg_write = 1;
    step();
    clearIn();
    id_valid = 1; id_rs = 9; id_uses_rs = 1; rf_rdata1 = 32'hBAD;
    step();
    check("alu_bubble", ex_valid, 0);
    mem_valid = 1; mem_reg_write = 1; mem_waddr = 9; mem_result = 32'h1234;
    step();
    check("alu_fwd_op_a", ex_op_a, 32'h1234);
    check("alu_stall_count", stall_count, 1);

    // Load directly ahead: two stalls, then forward from WB.
    clearIn();
    id_valid = 1; id_dst = 10; id_reg_write = 1; id_mem_read = 1;
    step();
    clearIn();
    id_valid = 1; id_rt = 10; id_uses_rt = 1;
    step();
    mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_waddr = 10;
    step();
    clearIn();
    id_valid = 1; id_rt = 10; id_uses_rt = 1;
    wb_reg_write = 1; wb_waddr = 10; wb_wdata = 32'hDEADBEEF; rf_rdata2 = 0;
    step();
    check("load_fwd_op_b", ex_op_b, 32'hDEADBEEF);
    check("load_stall_count", stall_count, 3);

    // Operand priority table.
    foreach (vecs[i]) begin
      clearIn();
      id_valid = 1; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_imm = i;
      mem_valid = vecs[i].memV; mem_reg_write = vecs[i].memW; mem_mem_read = vecs[i].memLoad;
      mem_waddr = vecs[i].memA; mem_result = vecs[i].memR;
      wb_reg_write = vecs[i].wbW; wb_waddr = vecs[i].wbA; wb_wdata = vecs[i].wbD;
      rf_rdata1 = vecs[i].rf1; rf_rdata2 = vecs[i].rf2;
      step();
      check($sformatf("vec%0d_op_a", i), ex_op_a, vecs[i].expA);
      check($sformatf("vec%0d_op_b", i), ex_op_b, vecs[i].expB);
    end

    // Flush while a hazard is present: flush wins.
    clearIn();
    id_valid = 1; id_dst = 13; id_reg_write = 1;
    step();
    savedCnt = stall_count;
    clearIn();
    id_valid = 1; id_rs = 13; id_uses_rs = 1; flush = 1;
    #1;
    check("flush_stall_out", stall_out, 0);
    step();
    check("flush_ex_valid", ex_valid, 0);
    check("flush_stall_count", stall_count, savedCnt);

    // Random traffic on a small register window to provoke matches.
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs = $urandom_range(0, 3); id_rt = $urandom_range(0, 3);
      id_uses_rs = $urandom; id_uses_rt = $urandom;
      id_dst = $urandom_range(0, 3); id_reg_write = $urandom; id_mem_read = $urandom;
      id_imm = $urandom; id_ctrl = $urandom; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      mem_valid = $urandom; mem_reg_write = $urandom; mem_mem_read = ($urandom_range(0, 3) == 0);
      mem_waddr = $urandom_range(0, 3); mem_result = $urandom;
      wb_reg_write = $urandom; wb_waddr = $urandom_range(0, 3); wb_wdata = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      step();
    end

    // Reset in the middle of a sustained stall.
    clearIn();
    id_valid = 1; id_rs = 2; id_uses_rs = 1;
    mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_waddr = 2;
    repeat (3) step();
    #2;
    reset_n = 0;
    #1;
    modelReset();
    check("midrst_stall_out", stall_out, 0);
    check("midrst_stall_count", stall_count, 0);
    check("midrst_ex_valid", ex_valid, 0);
    @(negedge clock);
    reset_n = 1;
    clearIn();
    id_valid = 1; id_rs = 2; id_uses_rs = 1; rf_rdata1 = 32'h77;
    step();
    check("midrst_resume_op_a", ex_op_a, 32'h77);

    // Saturation: hold a load-use hazard for 2^16+3 cycles.
    clearIn();
    id_valid = 1; id_rs = 2; id_uses_rs = 1;
    mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_waddr = 2;
    repeat (65539) step();
    check("sat_stall_count", stall_count, 32'hFFFF);
    step();
    check("sat_hold", stall_count, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
